// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus transmitter launch bundle.
//   req_valid/req_data/req_ready : N_REQ requesters, byte i at [i*DATA_W +: DATA_W]
//   tx_start/tx_data/tx_busy     : launch pulse, held byte, transmitter frame flag
// slave  = arbiter side, master = clients + transmitter side.
interface uart_tx_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    tx_start;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_busy;

   modport slave  (input  req_valid, req_data, tx_busy,
                   output req_ready, tx_start, tx_data);
   modport master (output req_valid, req_data, tx_busy,
                   input  req_ready, tx_start, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among N_REQ clients.
//   clk, rst (async, active low)
//   enable      : permits new grants only; frames in flight always complete
//   bus         : requester handshake + transmitter launch (slave modport)
//   grant_id    : current / last granted requester
//   busy        : high outside IDLE
//   timeout_err : one-cycle pulse when the watchdog aborts a wait state
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   uart_tx_arbiter_if.slave         bus,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     timeout_err
);
   localparam int ID_W = $clog2(N_REQ);
   localparam int WD_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win_idx;
   logic            win_found;
   logic            grant_ok;
   logic [WD_W-1:0] wd;
   logic            wd_expired;
   int              idx;

   // Search upward from ptr+1 with wrap; first set bit wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!win_found && bus.req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   assign grant_ok   = (state == IDLE) && enable && win_found;
   assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

   // Gated by rst so ready reads 0 while reset is held, even with requests pending.
   always_comb begin
      bus.req_ready = '0;
      if (grant_ok && rst)
         bus.req_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         ptr          <= ID_W'(N_REQ - 1);
         wd           <= '0;
         bus.tx_start <= 1'b0;
         bus.tx_data  <= '0;
         grant_id     <= '0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         bus.tx_start <= 1'b0;
         timeout_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  bus.tx_data  <= bus.req_data[win_idx*DATA_W +: DATA_W];
                  grant_id     <= win_idx;
                  bus.tx_start <= 1'b1;
                  busy         <= 1'b1;
                  state        <= LAUNCH;
               end
            end
            LAUNCH: begin
               wd    <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  wd    <= '0;
                  state <= WAIT_DONE;
               end else if (wd_expired) begin
                  // Aborted requester still counts as served: it loses its turn.
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  ptr         <= grant_id;
                  state       <= IDLE;
               end else if (!(&wd)) begin
                  wd <= wd + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  busy  <= 1'b0;
                  ptr   <= grant_id;
                  state <= IDLE;
               end else if (wd_expired) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  ptr         <= grant_id;
                  state       <= IDLE;
               end else if (!(&wd)) begin
                  wd <= wd + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
